// File: rtl/seq_det_arbiter.sv
// Shared serial pattern detector, time-multiplexed among NCH requesters.
// A round-robin arbiter accepts one bit per cycle from one channel. Each
// channel keeps its own history, fill level and saturating match counter,
// so interleaved streams never disturb each other. Overlapping matches count.
module seq_det_arbiter #(
    parameter int NCH      = 4,
    parameter int PLEN_MAX = 8,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [PLEN_MAX-1:0] cfg_pattern,
    input  logic [3:0]          cfg_len,
    output logic                cfg_err,
    input  logic [NCH-1:0]      req,
    input  logic [NCH-1:0]      bit_in,
    output logic [NCH-1:0]      gnt,
    output logic [NCH-1:0]      match_vec,
    input  logic [2:0]          rd_ch,
    output logic [CNT_W-1:0]    rd_cnt,
    output logic                armed
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [0:0] {
        ST_UNCFG = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                state_r;
    logic                  armed_r;
    logic                  cfg_err_r;
    logic [NCH-1:0]        match_vec_r;
    logic [PLEN_MAX-1:0]   pat_r;
    logic [3:0]            len_r;
    logic [PW-1:0]         ptr_r;
    logic [PLEN_MAX-1:0]   hist_r [NCH];
    logic [3:0]            fill_r [NCH];
    logic [CNT_W-1:0]      cnt_r  [NCH];

    logic                  cfg_ok_s;
    logic                  load_s;
    logic                  grant_en_s;
    logic                  found_s;
    logic [NCH-1:0]        gnt_s;
    logic [PW-1:0]         gnt_idx_s;
    logic [PW-1:0]         ptr_nxt_s;
    logic                  xfer_s;
    logic [PLEN_MAX-1:0]   hist_nxt_s [NCH];
    logic [3:0]            fill_nxt_s [NCH];
    logic [NCH-1:0]        match_s;
    logic [PLEN_MAX-1:0]   mask_s;
    logic [CNT_W-1:0]      rd_cnt_s;

    // Mask selecting the low 'len' bits of the match window.
    function automatic logic [PLEN_MAX-1:0] len_mask(input logic [3:0] len);
        logic [PLEN_MAX-1:0] m;
        m = '0;
        for (int b = 0; b < PLEN_MAX; b++) begin
            if (b < int'(len)) begin
                m[b] = 1'b1;
            end else begin
                m[b] = 1'b0;
            end
        end
        return m;
    endfunction

    // Config legality; a legal write always takes precedence over a grant.
    always_comb begin
        cfg_ok_s   = (cfg_len >= 4'd1) && (cfg_len <= 4'(PLEN_MAX));
        load_s     = cfg_we && cfg_ok_s;
        grant_en_s = (state_r == ST_RUN) && !load_s;
    end

    // Round-robin search starting at the pointer, wrapping modulo NCH.
    always_comb begin
        gnt_s     = '0;
        gnt_idx_s = '0;
        found_s   = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            for (int i = 0; i < NCH; i++) begin
                if (!found_s && req[i] && (((int'(ptr_r) + k) % NCH) == i)) begin
                    found_s   = 1'b1;
                    gnt_s[i]  = 1'b1;
                    gnt_idx_s = PW'(i);
                end else begin
                    found_s = found_s;
                end
            end
        end
        if (!grant_en_s) begin
            gnt_s = '0;
        end else begin
            gnt_s = gnt_s;
        end
        xfer_s = |(gnt_s & req);
        if (gnt_idx_s == PW'(NCH - 1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = gnt_idx_s + PW'(1);
        end
    end

    // Next history/fill per channel and the match decision on the updated window.
    always_comb begin
        mask_s = len_mask(len_r);
        for (int i = 0; i < NCH; i++) begin
            hist_nxt_s[i] = {hist_r[i][PLEN_MAX-2:0], bit_in[i]};
            if (fill_r[i] == 4'(PLEN_MAX)) begin
                fill_nxt_s[i] = fill_r[i];
            end else begin
                fill_nxt_s[i] = fill_r[i] + 4'd1;
            end
            match_s[i] = (fill_nxt_s[i] >= len_r) &&
                         (((hist_nxt_s[i] ^ pat_r) & mask_s) == '0);
        end
    end

    // Counter readback mux; out-of-range channel selects read as zero.
    always_comb begin
        rd_cnt_s = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_ch == 3'(i)) begin
                rd_cnt_s = cnt_r[i];
            end else begin
                rd_cnt_s = rd_cnt_s;
            end
        end
    end

    // Control FSM: configuration state, armed flag, error pulse and RR pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_UNCFG;
            armed_r   <= 1'b0;
            cfg_err_r <= 1'b0;
            pat_r     <= '0;
            len_r     <= 4'd0;
            ptr_r     <= '0;
        end else begin
            cfg_err_r <= cfg_we && !cfg_ok_s;
            case (state_r)
                ST_UNCFG: begin
                    if (load_s) begin
                        state_r <= ST_RUN;
                        armed_r <= 1'b1;
                        pat_r   <= cfg_pattern;
                        len_r   <= cfg_len;
                    end else begin
                        state_r <= ST_UNCFG;
                        armed_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    armed_r <= 1'b1;
                    if (load_s) begin
                        pat_r <= cfg_pattern;
                        len_r <= cfg_len;
                    end else if (xfer_s) begin
                        ptr_r <= ptr_nxt_s;
                    end else begin
                        ptr_r <= ptr_r;
                    end
                end
                default: begin
                    state_r <= ST_UNCFG;
                    armed_r <= 1'b0;
                end
            endcase
        end
    end

    // Per-channel contexts: only the granted channel shifts in its bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_vec_r <= '0;
            for (int i = 0; i < NCH; i++) begin
                hist_r[i] <= '0;
                fill_r[i] <= 4'd0;
                cnt_r[i]  <= '0;
            end
        end else if (load_s) begin
            match_vec_r <= '0;
            for (int i = 0; i < NCH; i++) begin
                hist_r[i] <= '0;
                fill_r[i] <= 4'd0;
                cnt_r[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (gnt_s[i] && req[i]) begin
                    hist_r[i]      <= hist_nxt_s[i];
                    fill_r[i]      <= fill_nxt_s[i];
                    match_vec_r[i] <= match_s[i];
                    if (match_s[i] && (cnt_r[i] != {CNT_W{1'b1}})) begin
                        cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                    end else begin
                        cnt_r[i] <= cnt_r[i];
                    end
                end else begin
                    match_vec_r[i] <= 1'b0;
                end
            end
        end
    end

    assign gnt       = gnt_s;
    assign match_vec = match_vec_r;
    assign cfg_err   = cfg_err_r;
    assign armed     = armed_r;
    assign rd_cnt    = rd_cnt_s;

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Scoreboard bench for seq_det_arbiter: a behavioural model predicts grants
// and match pulses per cycle; expected pulses are queued and checked after
// the clock edge.
module tb_seq_det_arbiter;

    localparam int NCH      = 4;
    localparam int PLEN_MAX = 8;
    localparam int CNT_W    = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_we;
    logic [7:0]       cfg_pattern;
    logic [3:0]       cfg_len;
    logic             cfg_err;
    logic [3:0]       req;
    logic [3:0]       bit_in;
    logic [3:0]       gnt;
    logic [3:0]       match_vec;
    logic [2:0]       rd_ch;
    logic [7:0]       rd_cnt;
    logic             armed;

    typedef struct packed {
        logic [3:0] mv;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    int   m_armed;
    int   m_pat;
    int   m_len;
    int   m_ptr;
    int   m_hist [NCH];
    int   m_fill [NCH];
    int   m_cnt  [NCH];

    // stream 1,1,0,1 : element p is the p-th bit sent
    logic [3:0] seq = 4'b1011;

    seq_det_arbiter #(.NCH(NCH), .PLEN_MAX(PLEN_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_err(cfg_err), .req(req), .bit_in(bit_in),
        .gnt(gnt), .match_vec(match_vec), .rd_ch(rd_ch), .rd_cnt(rd_cnt),
        .armed(armed)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_armed = 0; m_pat = 0; m_len = 0; m_ptr = 0;
        for (int c = 0; c < NCH; c++) begin
            m_hist[c] = 0; m_fill[c] = 0; m_cnt[c] = 0;
        end
        sb.delete();
    endtask

    // One clock of stimulus; the model predicts grant and pushes the expected outputs.
    task automatic drive(input logic we, input logic [7:0] pat, input logic [3:0] len,
                         input logic [3:0] r, input logic [3:0] b,
                         output logic [3:0] eg, output logic [3:0] ag);
        exp_t e;
        int   g;
        bit   legal;
        @(negedge clk);
        cfg_we = we; cfg_pattern = pat; cfg_len = len; req = r; bit_in = b;
        #1;
        ag    = gnt;
        legal = (len >= 1) && (len <= PLEN_MAX);
        eg    = '0;
        e.mv  = '0;
        e.err = we && !legal;
        g     = -1;
        if (m_armed != 0 && !(we && legal)) begin
            for (int k = 0; k < NCH; k++) begin
                if (g < 0 && r[(m_ptr + k) % NCH]) g = (m_ptr + k) % NCH;
            end
        end
        if (g >= 0) begin
            eg[g]     = 1'b1;
            m_hist[g] = (m_hist[g] * 2 + int'(b[g])) % 256;
            if (m_fill[g] < PLEN_MAX) m_fill[g]++;
            if (m_fill[g] >= m_len && (m_hist[g] % (1 << m_len)) == (m_pat % (1 << m_len))) begin
                e.mv[g] = 1'b1;
                if (m_cnt[g] < 255) m_cnt[g]++;
            end
            m_ptr = (g + 1) % NCH;
        end
        if (we && legal) begin
            m_pat = int'(pat); m_len = int'(len); m_armed = 1;
            for (int c = 0; c < NCH; c++) begin
                m_hist[c] = 0; m_fill[c] = 0; m_cnt[c] = 0;
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] eg, ag;
        exp_t e;
        reset = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0;
        req = '0; bit_in = '0; rd_ch = '0;
        model_reset();
        #12;
        total++; if (armed !== 1'b0) begin bad++; $display("FAIL reset_armed got=%b want=0", armed); end
        total++; if (gnt !== 4'b0) begin bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
        total++; if (match_vec !== 4'b0) begin bad++; $display("FAIL reset_match got=%b want=0000", match_vec); end
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_cfg_err got=%b want=0", cfg_err); end
        total++; if (rd_cnt !== 8'd0) begin bad++; $display("FAIL reset_rd_cnt got=%0d want=0", rd_cnt); end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 8'h00, 4'd0, 4'b1111, 4'b0000, eg, ag);
            e = sb.pop_front();
            total++; if (ag !== eg) begin bad++; $display("FAIL uncfg_gnt cyc=%0d got=%b want=%b", i, ag, eg); end
            total++; if (armed !== 1'b0) begin bad++; $display("FAIL uncfg_armed cyc=%0d got=%b want=0", i, armed); end
            total++; if (match_vec !== e.mv) begin bad++; $display("FAIL uncfg_match got=%b want=%b", match_vec, e.mv); end
        end
        drive(1'b1, 8'h0D, 4'd4, 4'b0000, 4'b0000, eg, ag);
        e = sb.pop_front();
        total++; if (armed !== 1'b1) begin bad++; $display("FAIL cfg_armed got=%b want=1", armed); end
        total++; if (cfg_err !== e.err) begin bad++; $display("FAIL cfg_err_legal got=%b want=%b", cfg_err, e.err); end
    endtask

    task automatic test_single_channel();
        logic [3:0] eg, ag;
        logic [6:0] bits = 7'b1011011; // bits[k] is k-th bit sent: 1,1,0,1,1,0,1
        exp_t e;
        for (int k = 0; k < 7; k++) begin
            drive(1'b0, 8'h0D, 4'd4, 4'b0001, {3'b000, bits[k]}, eg, ag);
            e = sb.pop_front();
            total++; if (ag !== eg) begin bad++; $display("FAIL single_gnt bit=%0d got=%b want=%b", k, ag, eg); end
            total++; if (match_vec !== e.mv) begin bad++; $display("FAIL single_match bit=%0d got=%b want=%b", k, match_vec, e.mv); end
            total++;
            if (match_vec[0] !== ((k == 3) || (k == 6))) begin
                bad++; $display("FAIL single_pulse bit=%0d got=%b", k, match_vec[0]);
            end
        end
        rd_ch = 3'd0; #1;
        total++; if (rd_cnt !== 8'd2) begin bad++; $display("FAIL single_cnt got=%0d want=2", rd_cnt); end
    endtask

    task automatic test_round_robin();
        logic [3:0] eg, ag, r, b;
        logic [3:0] ord [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int   pos [NCH];
        exp_t e;
        @(negedge clk); reset = 1'b0; model_reset();
        @(negedge clk); reset = 1'b1;
        drive(1'b1, 8'h0D, 4'd4, 4'b0000, 4'b0000, eg, ag);
        void'(sb.pop_front());
        for (int c = 0; c < NCH; c++) pos[c] = 0;
        for (int i = 0; i < 16; i++) begin
            for (int c = 0; c < NCH; c++) begin
                r[c] = (pos[c] < 4);
                b[c] = seq[pos[c] % 4];
            end
            drive(1'b0, 8'h0D, 4'd4, r, b, eg, ag);
            e = sb.pop_front();
            total++; if (ag !== eg) begin bad++; $display("FAIL rr_gnt cyc=%0d got=%b want=%b", i, ag, eg); end
            if (i < 5) begin
                total++; if (ag !== ord[i]) begin bad++; $display("FAIL rr_order cyc=%0d got=%b want=%b", i, ag, ord[i]); end
            end
            total++; if (match_vec !== e.mv) begin bad++; $display("FAIL rr_match cyc=%0d got=%b want=%b", i, match_vec, e.mv); end
            for (int c = 0; c < NCH; c++) if (eg[c]) pos[c]++;
        end
        for (int c = 0; c < NCH; c++) begin
            rd_ch = 3'(c); #1;
            total++; if (rd_cnt !== 8'd1) begin bad++; $display("FAIL rr_cnt ch=%0d got=%0d want=1", c, rd_cnt); end
        end
    endtask

    task automatic test_cfg_err();
        logic [3:0] eg, ag;
        logic [3:0] lens [4] = '{4'd0, 4'd9, 4'd4, 4'd4};
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            drive(k < 2, 8'hFF, lens[k], 4'b0001, {3'b000, seq[k]}, eg, ag);
            e = sb.pop_front();
            total++; if (ag !== eg) begin bad++; $display("FAIL err_gnt k=%0d got=%b want=%b", k, ag, eg); end
            total++; if (cfg_err !== e.err) begin bad++; $display("FAIL err_pulse k=%0d got=%b want=%b", k, cfg_err, e.err); end
            total++; if (match_vec !== e.mv) begin bad++; $display("FAIL err_match k=%0d got=%b want=%b", k, match_vec, e.mv); end
        end
        total++; if (match_vec !== 4'b0001) begin bad++; $display("FAIL err_old_pattern got=%b want=0001", match_vec); end
        drive(1'b1, 8'h0D, 4'd4, 4'b0001, 4'b0001, eg, ag);
        e = sb.pop_front();
        total++; if (ag !== 4'b0000) begin bad++; $display("FAIL cfg_wins_gnt got=%b want=0000", ag); end
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_legal_err got=%b want=0", cfg_err); end
        for (int c = 0; c < NCH; c++) begin
            rd_ch = 3'(c); #1;
            total++; if (rd_cnt !== 8'd0) begin bad++; $display("FAIL cfg_clear ch=%0d got=%0d want=0", c, rd_cnt); end
        end
    endtask

    task automatic test_saturate();
        logic [3:0] eg, ag;
        exp_t e;
        for (int i = 0; i < 1200; i++) begin
            drive(1'b0, 8'h0D, 4'd4, 4'b0100, {1'b0, seq[i % 4], 2'b00}, eg, ag);
            e = sb.pop_front();
            total++; if (ag !== eg) begin bad++; $display("FAIL sat_gnt cyc=%0d got=%b want=%b", i, ag, eg); end
            total++; if (match_vec !== e.mv) begin bad++; $display("FAIL sat_match cyc=%0d got=%b want=%b", i, match_vec, e.mv); end
        end
        rd_ch = 3'd2; #1;
        total++; if (rd_cnt !== 8'd255) begin bad++; $display("FAIL sat_cnt got=%0d want=255", rd_cnt); end
        rd_ch = 3'd4; #1;
        total++; if (rd_cnt !== 8'd0) begin bad++; $display("FAIL rd_oob4 got=%0d want=0", rd_cnt); end
        rd_ch = 3'd7; #1;
        total++; if (rd_cnt !== 8'd0) begin bad++; $display("FAIL rd_oob7 got=%0d want=0", rd_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] eg, ag;
        exp_t e;
        drive(1'b0, 8'h0D, 4'd4, 4'b0001, 4'b0001, eg, ag);
        void'(sb.pop_front());
        drive(1'b0, 8'h0D, 4'd4, 4'b0001, 4'b0001, eg, ag);
        void'(sb.pop_front());
        @(negedge clk);
        req = 4'b0001;
        #2 reset = 1'b0;
        model_reset();
        #1;
        total++; if (armed !== 1'b0) begin bad++; $display("FAIL mid_armed got=%b want=0", armed); end
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL mid_gnt got=%b want=0000", gnt); end
        for (int c = 0; c < NCH; c++) begin
            rd_ch = 3'(c); #1;
            total++; if (rd_cnt !== 8'd0) begin bad++; $display("FAIL mid_cnt ch=%0d got=%0d want=0", c, rd_cnt); end
        end
        @(negedge clk); reset = 1'b1;
        drive(1'b1, 8'h0D, 4'd4, 4'b0000, 4'b0000, eg, ag);
        void'(sb.pop_front());
        for (int k = 2; k < 4; k++) begin
            drive(1'b0, 8'h0D, 4'd4, 4'b0001, {3'b000, seq[k]}, eg, ag);
            e = sb.pop_front();
            total++; if (match_vec !== e.mv) begin bad++; $display("FAIL mid_match k=%0d got=%b want=%b", k, match_vec, e.mv); end
            total++; if (match_vec !== 4'b0000) begin bad++; $display("FAIL mid_nomatch k=%0d got=%b want=0000", k, match_vec); end
        end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_round_robin();
        test_cfg_err();
        test_saturate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_det_arbiter.md
Name: seq_det_arbiter

Overview:
Shared serial pattern-detection engine time-multiplexed among NCH serial requesters. A round-robin arbiter accepts one bit per cycle from one channel. Per-channel bit history is kept in context registers and compared against a runtime-programmable pattern of 1..PLEN_MAX bits, with overlapping matches allowed. The block sits between the serial front-ends and the event/interrupt logic, and replaces per-channel hard-wired Mealy detectors.

Parameters:
NCH, 4, number of requesting channels (2..8)
PLEN_MAX, 8, maximum pattern length in bits
CNT_W, 8, width of each per-channel saturating match counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
cfg_we  input  1  configuration write strobe
cfg_pattern  input  PLEN_MAX  pattern bits; bit 0 is the most recent bit in the match window
cfg_len  input  4  pattern length; legal range 1..PLEN_MAX
cfg_err  output  1  one-cycle pulse when a cfg_we carries an illegal cfg_len
req  input  NCH  per-channel "bit available"
bit_in  input  NCH  per-channel serial data bit, valid while its req is high
gnt  output  NCH  one-hot grant, combinational from req and arbiter pointer
match_vec  output  NCH  registered one-cycle pulse per channel on a match
rd_ch  input  3  channel select for counter readback
rd_cnt  output  CNT_W  match count of channel rd_ch, combinational
armed  output  1  high when in RUN

Behaviour:
- Reset values (reset=0, asynchronous): state=UNCFG, armed=0, gnt=0, match_vec=0, cfg_err=0, all histories=0, all fill counters=0, all match counters=0, RR pointer=0 (channel 0 has highest priority).
- FSM states:
  - UNCFG: gnt forced 0. A legal cfg_we loads pattern and length, then moves to RUN. An illegal cfg_we stays in UNCFG and pulses cfg_err on the next cycle.
  - RUN: armed=1, arbitration active. A legal cfg_we reloads pattern and length, clears all histories, fill counters and match counters, and forces gnt=0 in that cycle. An illegal cfg_we keeps the old config, pulses cfg_err, and does not block grants.
- Arbitration:
  - Grant goes to the first channel i with req[i]=1, searching from ptr, ptr+1, ... modulo NCH.
  - The transfer occurs when req[i] and gnt[i] are both high.
  - After a transfer, ptr becomes i+1 modulo NCH. With no transfer, ptr holds.
  - Requesters hold req and bit_in until granted.
  - Each channel waits at most NCH-1 cycles.
- Per-channel context on transfer:
  - hist[i] <= {hist[i][PLEN_MAX-2:0], bit_in[i]}
  - fill[i] saturates at PLEN_MAX.
- Match condition:
  - After the update, fill[i] >= cfg_len and the low cfg_len bits of hist[i] equal the low cfg_len bits of cfg_pattern.
  - On a match, match_vec[i]=1 in the next cycle. The latency is 1 cycle from the grant edge.
  - On a match, cnt[i] increments and saturates at 2^CNT_W-1.
- Overlap: the history is never cleared on a match. With pattern 11 (len 2), the input 111 gives 2 matches.
- Contexts of non-granted channels are untouched, so interleaving does not corrupt any channel's stream.
- rd_ch >= NCH returns rd_cnt=0.
- Simultaneous cfg_we and req in RUN: the config wins and no bit is accepted in that cycle.
- Reset mid-stream: everything returns to UNCFG immediately. Pending req are dropped, and the requesters must re-present their bits.

Test Plan:
- Reset, then req=4'b1111 with no cfg -> gnt=0 for 10 cycles, armed=0. Then cfg_we with len=4, pattern=4'b1101 -> armed=1 on the next cycle.
- Channel 0 only, bits 1,1,0,1,1,0,1 (pattern 1101, len 4) -> match_vec[0] pulses 1 cycle after the 4th and 7th bits, and rd_ch=0 gives rd_cnt=2.
- req=4'b1111 held -> grants 0,1,2,3,0 in consecutive cycles. Each channel is fed its own 1101 stream -> every channel matches once, with no cross-channel interference.
- cfg_we with len=0 and with len=9 in RUN -> cfg_err pulses each time and the old pattern stays active. A following legal cfg_we -> all counters read 0.
- Channel 2, 300 matching patterns -> rd_cnt saturates at 255.
- reset asserted mid-stream after 2 of 4 bits -> armed=0 and all counters 0. After reconfig, two more bits give no match because fill < len.
